lif_spike_gen: RTL and testbench

//  Leaky integrate-and-fire neuron. It integrates a signed input current into a membrane potential.
//  It emits a registered one-tick spike when the potential reaches threshold, then enforces a refractory period.

---
 rtl/lif_spike_gen_if.sv | 21 ++
 rtl/lif_spike_gen.sv | 106 ++++++++++
 tb/tb_lif_spike_gen.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_spike_gen_if.sv
// Input-current stream between a current source and the LIF neuron.
// The neuron never back-pressures, but in_ready is still carried for the handshake.
interface lif_spike_gen_if #(
    parameter int VW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [VW-1:0] in_current;

    modport master (
        output in_valid,
        output in_current,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_current,
        output in_ready
    );
endinterface

// File: rtl/lif_spike_gen.sv
// Leaky integrate-and-fire neuron: leaky integration of a signed current, a one-tick
// registered spike at threshold, then a refractory window that discards inputs.
module lif_spike_gen #(
    parameter int                   VW      = 16,
    parameter logic signed [VW-1:0] V_RESET = '0,
    parameter int                   RW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    lif_spike_gen_if.slave       in_if,
    input  logic [3:0]           leak_shift,
    input  logic signed [VW-1:0] v_th,
    input  logic [RW-1:0]        refrac_len,
    output logic                 spike_o,
    output logic signed [VW-1:0] v_mem_o,
    output logic                 refrac_o,
    output logic [15:0]          drop_cnt_o
);

    typedef enum logic {
        ST_INTEG   = 1'b0,
        ST_REFRACT = 1'b1
    } state_t;

    localparam logic signed [VW+1:0] SAT_MAX = {3'b000, {(VW-1){1'b1}}};
    localparam logic signed [VW+1:0] SAT_MIN = {3'b111, {(VW-1){1'b0}}};

    function automatic logic signed [VW-1:0] sat_vw(input logic signed [VW+1:0] x);
        if (x > SAT_MAX)
            return SAT_MAX[VW-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[VW-1:0];
        else
            return x[VW-1:0];
    endfunction

    state_t               r_state;
    logic [RW-1:0]        r_cnt;
    logic signed [VW-1:0] r_v;
    logic                 r_spike;
    logic [15:0]          r_drop;

    logic signed [VW-1:0] w_leak;
    logic signed [VW+1:0] w_v_ext;
    logic signed [VW+1:0] w_leak_ext;
    logic signed [VW+1:0] w_cur_ext;
    logic signed [VW+1:0] w_sum;
    logic signed [VW-1:0] w_sat;
    logic                 w_fire;

    // Integration datapath: two guard bits so v - leak + current cannot wrap before saturation
    assign w_leak     = r_v >>> leak_shift;
    assign w_v_ext    = {{2{r_v[VW-1]}}, r_v};
    assign w_leak_ext = {{2{w_leak[VW-1]}}, w_leak};
    assign w_cur_ext  = in_if.in_valid ? {{2{in_if.in_current[VW-1]}}, in_if.in_current} : '0;
    assign w_sum      = w_v_ext - w_leak_ext + w_cur_ext;
    assign w_sat      = sat_vw(w_sum);
    assign w_fire     = (w_sat >= v_th);

    assign in_if.in_ready = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INTEG;
            r_cnt   <= '0;
            r_v     <= V_RESET;
            r_spike <= 1'b0;
            r_drop  <= '0;
        end else if (clk_en) begin
            case (r_state)
                ST_INTEG: begin
                    if (w_fire) begin
                        r_spike <= 1'b1;
                        r_v     <= V_RESET;
                        if (refrac_len != '0) begin
                            r_state <= ST_REFRACT;
                            r_cnt   <= refrac_len - 1'b1;
                        end
                    end else begin
                        r_spike <= 1'b0;
                        r_v     <= w_sat;
                    end
                end
                ST_REFRACT: begin
                    r_spike <= 1'b0;
                    r_v     <= V_RESET;
                    // Inputs arriving now are accepted and thrown away; count them
                    if (in_if.in_valid && (r_drop != 16'hFFFF))
                        r_drop <= r_drop + 1'b1;
                    if (r_cnt == '0)
                        r_state <= ST_INTEG;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                default: r_state <= ST_INTEG;
            endcase
        end
    end

    assign spike_o    = r_spike;
    assign v_mem_o    = r_v;
    assign refrac_o   = (r_state == ST_REFRACT);
    assign drop_cnt_o = r_drop;

endmodule

// File: tb/tb_lif_spike_gen.sv
// Bench for lif_spike_gen: directed vector table, hand-written corner sequences,
// and randomized ticks compared against an integer-arithmetic neuron model.
module tb_lif_spike_gen;

    localparam int VW = 16;
    localparam int RW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clk_en = 1'b0;
    logic [3:0]           leak_shift = 4'd15;
    logic signed [VW-1:0] v_th = 16'sd1000;
    logic [RW-1:0]        refrac_len = '0;
    logic                 spike_o;
    logic signed [VW-1:0] v_mem_o;
    logic                 refrac_o;
    logic [15:0]          drop_cnt_o;

    lif_spike_gen_if #(.VW(VW)) ifc ();

    lif_spike_gen #(.VW(VW), .V_RESET('0), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .in_if      (ifc.slave),
        .leak_shift (leak_shift),
        .v_th       (v_th),
        .refrac_len (refrac_len),
        .spike_o    (spike_o),
        .v_mem_o    (v_mem_o),
        .refrac_o   (refrac_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference neuron: plain integers, refractory tracked as "ticks remaining"
    int m_v, m_spike, m_ref_left, m_drop;

    typedef struct {
        bit en;
        bit vld;
        int cur;
        int rlen;
        int sp;
        int v;
        int rf;
        int dr;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_shr(input int v, input int s);
        int d;
        d = 1 << s;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic model_reset();
        m_v = 0; m_spike = 0; m_ref_left = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit en, input bit vld, input int cur);
        int sum;
        if (!en) return;
        if (m_ref_left > 0) begin
            m_ref_left--;
            if (vld && m_drop < 65535) m_drop++;
            m_spike = 0;
            m_v = 0;
        end else begin
            sum = m_v - floor_shr(m_v, int'(leak_shift)) + (vld ? cur : 0);
            if (sum > 32767) sum = 32767;
            if (sum < -32768) sum = -32768;
            if (sum >= int'(v_th)) begin
                m_spike = 1;
                m_v = 0;
                m_ref_left = int'(refrac_len);
            end else begin
                m_spike = 0;
                m_v = sum;
            end
        end
    endtask

    task automatic do_tick(input bit en, input bit vld, input int cur);
        clk_en = en;
        ifc.in_valid = vld;
        ifc.in_current = cur[VW-1:0];
        @(posedge clk);
        #1;
        model_step(en, vld, cur);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".spike"}, int'(spike_o), m_spike);
        check({tag, ".v"}, int'(v_mem_o), m_v);
        check({tag, ".refrac"}, int'(refrac_o), (m_ref_left > 0) ? 1 : 0);
        check({tag, ".drop"}, int'(drop_cnt_o), m_drop);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Directed vectors: 300 per tick toward threshold 1000, then refractory of 3
        tbl[0]  = '{1, 1, 300, 0, 0,  300, 0, 0};
        tbl[1]  = '{1, 1, 300, 0, 0,  600, 0, 0};
        tbl[2]  = '{1, 1, 300, 0, 0,  900, 0, 0};
        tbl[3]  = '{1, 1, 300, 0, 1,    0, 0, 0};
        tbl[4]  = '{1, 1, 300, 3, 0,  300, 0, 0};
        tbl[5]  = '{1, 1, 300, 3, 0,  600, 0, 0};
        tbl[6]  = '{1, 1, 300, 3, 0,  900, 0, 0};
        tbl[7]  = '{1, 1, 300, 3, 1,    0, 1, 0};
        tbl[8]  = '{1, 1, 300, 3, 0,    0, 1, 1};
        tbl[9]  = '{1, 1, 300, 3, 0,    0, 1, 2};
        tbl[10] = '{1, 1, 300, 3, 0,    0, 0, 3};
        tbl[11] = '{1, 1, 300, 3, 0,  300, 0, 3};

        ifc.in_valid = 1'b0;
        ifc.in_current = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.spike", int'(spike_o), 0);
        check("reset.v", int'(v_mem_o), 0);
        check("reset.refrac", int'(refrac_o), 0);
        check("reset.drop", int'(drop_cnt_o), 0);
        check("reset.in_ready", int'(ifc.in_ready), 1);
        rst = 1'b0;

        leak_shift = 4'd15;
        v_th = 16'sd1000;
        for (int i = 0; i < 12; i++) begin
            refrac_len = tbl[i].rlen[RW-1:0];
            do_tick(tbl[i].en, tbl[i].vld, tbl[i].cur);
            check($sformatf("tbl%0d.spike", i), int'(spike_o), tbl[i].sp);
            check($sformatf("tbl%0d.v", i), int'(v_mem_o), tbl[i].v);
            check($sformatf("tbl%0d.refrac", i), int'(refrac_o), tbl[i].rf);
            check($sformatf("tbl%0d.drop", i), int'(drop_cnt_o), tbl[i].dr);
            check($sformatf("tbl%0d.in_ready", i), int'(ifc.in_ready), 1);
        end

        // Async reset during refractory with counter loaded to 5, spike still high
        refrac_len = 8'd6;
        do_tick(1, 1, 800);
        check("arst.pre_spike", int'(spike_o), 1);
        check("arst.pre_refrac", int'(refrac_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.spike", int'(spike_o), 0);
        check("arst.v", int'(v_mem_o), 0);
        check("arst.refrac", int'(refrac_o), 0);
        check("arst.drop", int'(drop_cnt_o), 0);
        #1;
        rst = 1'b0;
        model_reset();

        // Leak decay from 4096 with shift 2
        refrac_len = '0;
        v_th = 16'sd32767;
        leak_shift = 4'd15;
        do_tick(1, 1, 4096);
        check("leak.load", int'(v_mem_o), 4096);
        leak_shift = 4'd2;
        do_tick(1, 0, 0);
        check("leak.t1", int'(v_mem_o), 3072);
        do_tick(1, 0, 0);
        check("leak.t2", int'(v_mem_o), 2304);
        do_tick(1, 0, 0);
        check("leak.t3", int'(v_mem_o), 1728);
        check("leak.spike", int'(spike_o), 0);

        // Negative potential floors toward zero; full leak with shift 0
        do_reset();
        do_tick(1, 1, -1);
        check("neg.load", int'(v_mem_o), -1);
        leak_shift = 4'd1;
        do_tick(1, 0, 0);
        check("neg.leak", int'(v_mem_o), 0);
        leak_shift = 4'd0;
        do_tick(1, 1, 500);
        do_tick(1, 1, 123);
        check("fullleak.v", int'(v_mem_o), 123);

        // Saturation at the positive rail must fire rather than wrap
        do_reset();
        leak_shift = 4'd15;
        v_th = 16'sd32767;
        do_tick(1, 1, 20000);
        check("sat.load", int'(v_mem_o), 20000);
        do_tick(1, 1, 32767);
        check("sat.spike", int'(spike_o), 1);
        check("sat.v", int'(v_mem_o), 0);

        // Spike held across disabled cycles
        do_reset();
        v_th = 16'sd1000;
        do_tick(1, 1, 1000);
        check("en.fire", int'(spike_o), 1);
        do_tick(0, 1, 700);
        check("en.hold1", int'(spike_o), 1);
        check("en.hold1v", int'(v_mem_o), 0);
        do_tick(0, 1, 700);
        check("en.hold2", int'(spike_o), 1);
        do_tick(1, 0, 0);
        check("en.clear", int'(spike_o), 0);

        // Threshold at or below reset with no refractory fires every tick
        v_th = 16'sd0;
        do_tick(1, 0, 0);
        check("every.t1", int'(spike_o), 1);
        do_tick(1, 1, -50);
        check("every.t2", int'(spike_o), 0);
        check("every.t2v", int'(v_mem_o), -50);

        // Randomized ticks against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit en, vld;
            int cur;
            logic signed [15:0] raw;
            en = ($urandom_range(0, 4) != 0);
            vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                raw = 16'($urandom);
                cur = int'(raw);
            end else begin
                cur = int'($urandom_range(0, 5000)) - 1500;
            end
            leak_shift = 4'($urandom_range(0, 15));
            v_th = 16'(int'($urandom_range(0, 8000)) - 1000);
            refrac_len = RW'($urandom_range(0, 4));
            do_tick(en, vld, cur);
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
